dct_transpose_buffer: RTL and testbench
=======================================

Name: dct_transpose_buffer

Overview:
Row-to-column transpose stage between the first (row) 1D-DCT pass and the second (column) pass of the 8x8 2D DCT.
- Accepts one 8-coefficient row per cycle from the row-DCT output (signed 12-bit).
- Emits the transposed 8x8 block one column per cycle with ready/valid handshake.
- Ping-pong double buffering so the row DCT can run at full rate with no stall.

Parameters:
DATA_W, 12, width of each signed coefficient (input and output).
N, 8, block dimension; fixed at 8 (port list is explicit 0..7).

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-low
i_valid  input  1  row on i_data0..7 valid this cycle
i_data0..i_data7  input  DATA_W each, signed  row elements, column index 0..7
o_in_ready  output  1  current write bank not full; combinational from state
i_out_ready  input  1  downstream accepts column this cycle
o_valid  output  1  column on o_data0..7 valid, registered
o_data0..o_data7  output  DATA_W each, signed  column elements, row index 0..7
o_col_idx  output  3  column index of presented column
o_last  output  1  presented column is column 7 of its block
o_overflow  output  1  sticky: a row arrived while the write bank was full

Behaviour:
- Reset (i_rst=0 at edge): wr_bank=0, rd_bank=0, wr_row=0, rd_col=0, bank_full=2'b00.
- Reset output values: o_valid=0, o_data*=0, o_col_idx=0, o_last=0, o_overflow=0; o_in_ready=1.
- Storage is not reset; its contents are don't-care after reset.
- Reset mid-block discards partial and full banks; no stale column is ever presented.
- Write path (i_valid=1 and bank_full[wr_bank]=0 at the edge):
  - mem[wr_bank][wr_row][k] <= i_data_k; wr_row increments.
  - On wr_row==7: bank_full[wr_bank]<=1, wr_bank toggles, wr_row<=0.
- Write drop (i_valid=1 and bank_full[wr_bank]=1): row is dropped, no state change except o_overflow<=1.
  - o_overflow holds until reset.
  - The full test uses the pre-edge bank_full value, even if the read side clears that bank on the same edge.
- Read advance condition: bank_full[rd_bank]=1 and (o_valid=0 or i_out_ready=1). On advance:
  - Load o_data_k <= mem[rd_bank][k][rd_col], o_col_idx<=rd_col, o_last<=(rd_col==7), o_valid<=1.
  - rd_col increments. On rd_col==7: bank_full[rd_bank]<=0, rd_bank toggles, rd_col<=0.
- Otherwise, if o_valid=1 and i_out_ready=1: o_valid<=0. If o_valid=1 and i_out_ready=0: all outputs held stable.
- Latency: 8th row of a block sampled at edge E; column 0 presented (o_valid=1) after edge E+1.
- Throughput: with i_out_ready tied 1, one column per cycle.
  - Continuous i_valid never overflows: bank A clears at E+8, and its next write is at E+9.
- Same-edge bank set and clear always target different banks; both take effect.
- No arithmetic; data passes bit-exact, signed values preserved.
- i_data sampled only when written; X on i_data with i_valid=0 has no effect.

Decomposition:
- Shared package dct_pkg:
  - DATA_W=12, N=8.
  - Coefficient typedef: signed [DATA_W-1:0].
  - 3-bit row/column index typedef.
  - Same package used by the row and column DCT stages.
- Sub-module dct_tpose_bank: one 8x8 register array.
  - Row write port: we, row index, 8 elements.
  - Combinational column read port: column index in, 8 elements out.
  - Instantiated twice; the top holds the control FSM (counters, bank_full, output register).

Test Plan:
1. Reset, then 8 rows with row r element k = r*8+k, i_out_ready=1 -> columns c=0..7, o_data_k = k*8+c; o_col_idx 0..7; o_last only at c=7; o_valid one edge after the 8th-row edge.
2. 4 blocks back-to-back, i_valid continuous, i_out_ready=1 -> 32 contiguous valid columns in block order; o_overflow stays 0; o_in_ready never drops.
3. i_out_ready=0, send 17 rows -> o_in_ready=0 after row 16; row 17 dropped, o_overflow=1 sticky; release i_out_ready -> blocks 1 then 2 output intact.
4. Toggle i_out_ready every other cycle during a block -> o_data/o_col_idx/o_last held stable while o_valid=1 and i_out_ready=0; no column lost or duplicated.
5. Rows containing -2048 and 2047 -> identical bit patterns at the transposed positions.
6. Reset asserted after 5 rows of a block -> no o_valid; the next 8 rows produce a clean block with o_col_idx starting at 0.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types for the 8x8 2D DCT pipeline (row pass, transpose, column pass).
package dct_pkg;

  localparam int DATA_W = 12;
  localparam int N      = 8;

  typedef logic signed [DATA_W-1:0] coef_t;
  typedef logic [2:0]               idx_t;
  typedef coef_t [N-1:0]            row_t;

endpackage

// File: rtl/dct_tpose_bank.sv
// One 8x8 coefficient array: written a row at a time, read a column at a time.
module dct_tpose_bank
  import dct_pkg::*;
(
  input  logic clk,
  input  logic we,
  input  idx_t wr_row,
  input  row_t wr_data,
  input  idx_t rd_col,
  output row_t rd_data
);

  // Storage is deliberately not reset; bank_full in the top guards every read.
  row_t mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_row] <= wr_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N; k++) begin
      rd_data[k] = mem[k][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong row-to-column transpose between the row and column 1D-DCT passes.
module dct_transpose_buffer
  import dct_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic signed [DATA_W-1:0] i_data0,
  input  logic signed [DATA_W-1:0] i_data1,
  input  logic signed [DATA_W-1:0] i_data2,
  input  logic signed [DATA_W-1:0] i_data3,
  input  logic signed [DATA_W-1:0] i_data4,
  input  logic signed [DATA_W-1:0] i_data5,
  input  logic signed [DATA_W-1:0] i_data6,
  input  logic signed [DATA_W-1:0] i_data7,
  output logic              o_in_ready,
  input  logic              i_out_ready,
  output logic              o_valid,
  output logic signed [DATA_W-1:0] o_data0,
  output logic signed [DATA_W-1:0] o_data1,
  output logic signed [DATA_W-1:0] o_data2,
  output logic signed [DATA_W-1:0] o_data3,
  output logic signed [DATA_W-1:0] o_data4,
  output logic signed [DATA_W-1:0] o_data5,
  output logic signed [DATA_W-1:0] o_data6,
  output logic signed [DATA_W-1:0] o_data7,
  output logic [2:0]        o_col_idx,
  output logic              o_last,
  output logic              o_overflow
);

  logic       wr_bank;
  logic       rd_bank;
  idx_t       wr_row;
  idx_t       rd_col;
  logic [1:0] bank_full;
  logic [1:0] bank_full_nxt;
  logic       wr_en;
  logic       wr_done;
  logic       rd_adv;
  logic       rd_done;
  row_t       in_row;
  row_t       rd_row0;
  row_t       rd_row1;
  row_t       rd_sel;
  row_t       out_row;

  assign in_row = {i_data7, i_data6, i_data5, i_data4,
                   i_data3, i_data2, i_data1, i_data0};

  assign o_in_ready = !bank_full[wr_bank];
  assign wr_en      = i_valid && !bank_full[wr_bank];
  assign wr_done    = wr_en && (wr_row == idx_t'(N - 1));
  assign rd_adv     = bank_full[rd_bank] && (!o_valid || i_out_ready);
  assign rd_done    = rd_adv && (rd_col == idx_t'(N - 1));
  assign rd_sel     = rd_bank ? rd_row1 : rd_row0;

  dct_tpose_bank u_bank0 (
    .clk     (i_clk),
    .we      (wr_en && !wr_bank),
    .wr_row  (wr_row),
    .wr_data (in_row),
    .rd_col  (rd_col),
    .rd_data (rd_row0)
  );

  dct_tpose_bank u_bank1 (
    .clk     (i_clk),
    .we      (wr_en && wr_bank),
    .wr_row  (wr_row),
    .wr_data (in_row),
    .rd_col  (rd_col),
    .rd_data (rd_row1)
  );

  // Set and clear never hit the same bank: a bank being written is never full.
  always_comb begin
    bank_full_nxt = bank_full;
    if (wr_done) begin
      bank_full_nxt[wr_bank] = 1'b1;
    end
    if (rd_done) begin
      bank_full_nxt[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_bank    <= 1'b0;
      rd_bank    <= 1'b0;
      wr_row     <= '0;
      rd_col     <= '0;
      bank_full  <= 2'b00;
      o_overflow <= 1'b0;
    end else begin
      bank_full <= bank_full_nxt;
      if (wr_en) begin
        wr_row <= wr_row + 3'd1;
        if (wr_done) begin
          wr_bank <= !wr_bank;
        end
      end else if (i_valid) begin
        o_overflow <= 1'b1;
      end
      if (rd_adv) begin
        rd_col <= rd_col + 3'd1;
        if (rd_done) begin
          rd_bank <= !rd_bank;
        end
      end
    end
  end

  // Output register: load on advance, retire on handshake, otherwise hold.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_valid   <= 1'b0;
      out_row   <= '0;
      o_col_idx <= '0;
      o_last    <= 1'b0;
    end else if (rd_adv) begin
      o_valid   <= 1'b1;
      out_row   <= rd_sel;
      o_col_idx <= rd_col;
      o_last    <= (rd_col == idx_t'(N - 1));
    end else if (o_valid && i_out_ready) begin
      o_valid <= 1'b0;
    end
  end

  assign o_data0 = out_row[0];
  assign o_data1 = out_row[1];
  assign o_data2 = out_row[2];
  assign o_data3 = out_row[3];
  assign o_data4 = out_row[4];
  assign o_data5 = out_row[5];
  assign o_data6 = out_row[6];
  assign o_data7 = out_row[7];

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Scoreboard bench for dct_transpose_buffer: rows in, transposed columns checked by a monitor.
module tb_dct_transpose_buffer;
  import dct_pkg::*;

  typedef struct packed {
    logic [8*DATA_W-1:0] data;
    logic [2:0]          col;
    logic                last;
  } exp_t;

  logic clk;
  logic rst;
  logic in_valid;
  logic out_ready;
  logic signed [DATA_W-1:0] din [8];
  logic in_ready;
  logic out_valid;
  logic signed [DATA_W-1:0] dout [8];
  logic [2:0] col_idx;
  logic last;
  logic overflow;

  exp_t sb [$];
  logic signed [DATA_W-1:0] rowv [8];
  logic signed [DATA_W-1:0] blk [8][8];
  int nrows;
  int tests;
  int fails;
  int run_len;
  int max_run;
  logic held_valid;
  logic [127:0] held;

  dct_transpose_buffer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (in_valid),
    .i_data0     (din[0]),
    .i_data1     (din[1]),
    .i_data2     (din[2]),
    .i_data3     (din[3]),
    .i_data4     (din[4]),
    .i_data5     (din[5]),
    .i_data6     (din[6]),
    .i_data7     (din[7]),
    .o_in_ready  (in_ready),
    .i_out_ready (out_ready),
    .o_valid     (out_valid),
    .o_data0     (dout[0]),
    .o_data1     (dout[1]),
    .o_data2     (dout[2]),
    .o_data3     (dout[3]),
    .o_data4     (dout[4]),
    .o_data5     (dout[5]),
    .o_data6     (dout[6]),
    .o_data7     (dout[7]),
    .o_col_idx   (col_idx),
    .o_last      (last),
    .o_overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8*DATA_W-1:0] outData();
    logic [8*DATA_W-1:0] v;
    for (int k = 0; k < 8; k++) v[k*DATA_W +: DATA_W] = dout[k];
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected columns of a completed block: column c element k is row k element c.
  task automatic pushBlock();
    exp_t e;
    for (int c = 0; c < 8; c++) begin
      e.data = '0;
      for (int k = 0; k < 8; k++) e.data[k*DATA_W +: DATA_W] = blk[k][c];
      e.col  = 3'(c);
      e.last = (c == 7);
      sb.push_back(e);
    end
    nrows = 0;
  endtask

  task automatic applyStimulus(input logic accept);
    checkOutput("in_ready", 128'(in_ready), 128'(accept));
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) din[k] = rowv[k];
    @(posedge clk); #1;
    if (accept) begin
      for (int k = 0; k < 8; k++) blk[nrows][k] = rowv[k];
      nrows++;
      if (nrows == 8) pushBlock();
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) din[k] = 'x;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic doReset();
    rst = 1'b0;
    in_valid = 1'b0;
    nrows = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ctrl", 128'({out_valid, last, overflow, in_ready, col_idx}), 128'({1'b0, 1'b0, 1'b0, 1'b1, 3'd0}));
    checkOutput("reset_data", 128'(outData()), 128'(0));
    rst = 1'b1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (!(sb.size() == 0 && !out_valid) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("drain_timeout", 128'(t >= 300), 128'(0));
  endtask

  // Monitor: a column is consumed at the edge after a negedge that sees valid and ready.
  always @(negedge clk) begin
    if (!rst) begin
      held_valid = 1'b0;
      run_len = 0;
    end else begin
      if (held_valid) begin
        checkOutput("held_stable", {out_valid, col_idx, last, outData()}, held);
        held_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_column", 128'(1), 128'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("column", 128'({outData(), col_idx, last}), 128'({e.data, e.col, e.last}));
        end
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
        if (out_valid) begin
          held = {out_valid, col_idx, last, outData()};
          held_valid = 1'b1;
        end
      end
    end
  end

  initial begin
    logic saw;
    tests = 0; fails = 0; nrows = 0; max_run = 0; run_len = 0; held_valid = 1'b0;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) din[k] = '0;

    // Test 1: basic transpose and latency
    doReset();
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) rowv[k] = 12'(r*8 + k);
      applyStimulus(1'b1);
    end
    in_valid = 1'b0;
    checkOutput("latency_not_yet", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    checkOutput("latency_first", 128'({out_valid, col_idx}), 128'({1'b1, 3'd0}));
    idle(1);
    drain();

    // Test 2: four blocks back-to-back at full rate
    max_run = 0;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 8; r++) begin
        for (int k = 0; k < 8; k++) rowv[k] = 12'(b*100 + r*8 + k - 500);
        applyStimulus(1'b1);
      end
    idle(1);
    drain();
    checkOutput("contiguous_run", 128'(max_run), 128'(32));
    checkOutput("no_overflow", 128'(overflow), 128'(0));

    // Test 3: stalled output, overflow on row 17
    out_ready = 1'b0;
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 8; k++) rowv[k] = 12'(r*16 + k*3 - 300);
      applyStimulus(1'b1);
    end
    for (int k = 0; k < 8; k++) rowv[k] = 12'h555;
    applyStimulus(1'b0);
    idle(3);
    checkOutput("overflow_set", 128'(overflow), 128'(1));
    out_ready = 1'b1;
    drain();
    checkOutput("overflow_sticky", 128'(overflow), 128'(1));
    doReset();

    // Test 4: backpressure toggling every cycle
    fork
      begin
        repeat (30) begin @(posedge clk); #1; out_ready = ~out_ready; end
        out_ready = 1'b1;
      end
    join_none
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) rowv[k] = 12'((r*16 + k)*13 - 700);
      applyStimulus(1'b1);
    end
    idle(1);
    drain();
    wait fork;
    drain();

    // Test 5: extreme signed values
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++)
        rowv[k] = (r == k) ? -12'sd2048 : (r + k == 7) ? 12'sd2047 : 12'(r*3 - k);
      applyStimulus(1'b1);
    end
    idle(1);
    drain();

    // Test 6: reset after a partial block
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 8; k++) rowv[k] = 12'h7A0 + 12'(r*8 + k);
      applyStimulus(1'b1);
    end
    in_valid = 1'b0;
    doReset();
    saw = 1'b0;
    repeat (10) begin @(posedge clk); #1; saw |= out_valid; end
    checkOutput("no_stale_column", 128'(saw), 128'(0));
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) rowv[k] = 12'(40 - r*8 - k);
      applyStimulus(1'b1);
    end
    idle(1);
    drain();

    checkOutput("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
